// File: rtl/decode_stage.sv
// Registered RV32I/RV32IM decode stage between fetch and execute.
// Every accepted beat is decoded combinationally and captured in an output
// register; an optional skid register holds a second decoded entry so that
// execute back-pressure never drops a fetch beat.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter bit SKID     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [31:0]     imm,
  output logic [4:0]      alu_op,
  output logic            rd_we,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            illegal
);

  localparam logic [4:0] ALU_AND    = 5'b00000;
  localparam logic [4:0] ALU_OR     = 5'b00001;
  localparam logic [4:0] ALU_ADD    = 5'b00010;
  localparam logic [4:0] ALU_XOR    = 5'b00011;
  localparam logic [4:0] ALU_SLL    = 5'b00100;
  localparam logic [4:0] ALU_SRL    = 5'b00101;
  localparam logic [4:0] ALU_SUB    = 5'b00110;
  localparam logic [4:0] ALU_SLT    = 5'b00111;
  localparam logic [4:0] ALU_SLTU   = 5'b01000;
  localparam logic [4:0] ALU_MUL    = 5'b01001;
  localparam logic [4:0] ALU_MULH   = 5'b01010;
  localparam logic [4:0] ALU_MULHSU = 5'b01011;
  localparam logic [4:0] ALU_MULHU  = 5'b01100;
  localparam logic [4:0] ALU_DIV    = 5'b01101;
  localparam logic [4:0] ALU_DIVU   = 5'b01110;
  localparam logic [4:0] ALU_REM    = 5'b01111;
  localparam logic [4:0] ALU_SRA    = 5'b10000;
  localparam logic [4:0] ALU_REMU   = 5'b10001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [4:0]      alu_op;
    logic            rd_we;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  // Base integer op selected by funct3 (shared by OP and OP-IMM).
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  // M-extension op selected by funct3.
  function automatic logic [4:0] m_op(input logic [2:0] f3);
    case (f3)
      3'b000:  m_op = ALU_MUL;
      3'b001:  m_op = ALU_MULH;
      3'b010:  m_op = ALU_MULHSU;
      3'b011:  m_op = ALU_MULHU;
      3'b100:  m_op = ALU_DIV;
      3'b101:  m_op = ALU_DIVU;
      3'b110:  m_op = ALU_REM;
      default: m_op = ALU_REMU;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  logic        dec_legal, dec_writes, dec_use1, dec_use2;
  logic [4:0]  dec_alu;
  logic [31:0] dec_imm;
  entry_t      dec;

  // Classify the incoming instruction; opcodes with [1:0] != 11 fall to default.
  always_comb begin
    dec_legal  = 1'b0;
    dec_writes = 1'b0;
    dec_use1   = 1'b0;
    dec_use2   = 1'b0;
    dec_alu    = ALU_ADD;
    dec_imm    = 32'b0;
    case (opcode)
      OPC_OP: begin
        dec_writes = 1'b1;
        dec_use1   = 1'b1;
        dec_use2   = 1'b1;
        case (funct7)
          7'b0000000: begin
            dec_legal = 1'b1;
            dec_alu   = base_op(funct3);
          end
          7'b0100000: begin
            if (funct3 == 3'b000) begin
              dec_legal = 1'b1;
              dec_alu   = ALU_SUB;
            end else if (funct3 == 3'b101) begin
              dec_legal = 1'b1;
              dec_alu   = ALU_SRA;
            end
          end
          7'b0000001: begin
            dec_legal = ENABLE_M;
            dec_alu   = m_op(funct3);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec_writes = 1'b1;
        dec_use1   = 1'b1;
        dec_imm    = imm_i;
        case (funct3)
          3'b001: begin
            dec_legal = (funct7 == 7'b0000000);
            dec_alu   = ALU_SLL;
          end
          3'b101: begin
            dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            dec_alu   = funct7[5] ? ALU_SRA : ALU_SRL;
          end
          default: begin
            dec_legal = 1'b1;
            dec_alu   = base_op(funct3);
          end
        endcase
      end
      OPC_LOAD: begin
        dec_legal  = !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
        dec_writes = 1'b1;
        dec_use1   = 1'b1;
        dec_imm    = imm_i;
      end
      OPC_STORE: begin
        dec_legal = (funct3 < 3'b011);
        dec_use1  = 1'b1;
        dec_use2  = 1'b1;
        dec_imm   = imm_s;
      end
      OPC_BRANCH: begin
        dec_legal = !(funct3 == 3'b010 || funct3 == 3'b011);
        dec_use1  = 1'b1;
        dec_use2  = 1'b1;
        dec_alu   = ALU_SUB;
        dec_imm   = imm_b;
      end
      OPC_JALR: begin
        dec_legal  = (funct3 == 3'b000);
        dec_writes = 1'b1;
        dec_use1   = 1'b1;
        dec_imm    = imm_i;
      end
      OPC_JAL: begin
        dec_legal  = 1'b1;
        dec_writes = 1'b1;
        dec_imm    = imm_j;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_legal  = 1'b1;
        dec_writes = 1'b1;
        dec_imm    = imm_u;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Illegal encodings keep their raw fields but lose every side effect.
  always_comb begin
    dec.pc       = in_pc;
    dec.instr    = in_instr;
    dec.rd       = in_instr[11:7];
    dec.rs1      = in_instr[19:15];
    dec.rs2      = in_instr[24:20];
    dec.illegal  = !dec_legal;
    dec.imm      = dec_legal ? dec_imm : 32'b0;
    dec.alu_op   = dec_legal ? dec_alu : ALU_ADD;
    dec.rd_we    = dec_legal && dec_writes && (in_instr[11:7] != 5'd0);
    dec.uses_rs1 = dec_legal && dec_use1;
    dec.uses_rs2 = dec_legal && dec_use2;
  end

  state_t state_reg, state_next;
  entry_t out_reg, out_next;
  entry_t skid_reg, skid_next;
  logic   accept, pop;

  assign accept = in_valid && in_ready;
  assign pop    = (state_reg != ST_EMPTY) && out_ready;

  // Buffer next-state: load output, park in skid, or promote skid; flush wins.
  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next = ST_ONE;
            out_next   = dec;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            out_next = dec;
          end else if (accept && SKID) begin
            state_next = ST_TWO;
            skid_next  = dec;
          end else if (pop) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_next = ST_ONE;
            out_next   = skid_reg;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // State and entry registers; reset leaves an ADD-coded empty entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= ST_EMPTY;
      out_reg          <= '0;
      out_reg.alu_op   <= ALU_ADD;
      skid_reg         <= '0;
      skid_reg.alu_op  <= ALU_ADD;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      skid_reg  <= skid_next;
    end
  end

  generate
    if (SKID) begin : g_skid_ready
      logic ready_reg;
      // Registered ready: low only while the buffer will hold two entries.
      always_ff @(posedge clk) begin
        if (!rst_n) ready_reg <= 1'b1;
        else        ready_reg <= (state_next != ST_TWO);
      end
      assign in_ready = rst_n && ready_reg;
    end else begin : g_comb_ready
      assign in_ready = rst_n && ((state_reg == ST_EMPTY) || out_ready);
    end
  endgenerate

  assign out_valid = (state_reg != ST_EMPTY);
  assign out_pc    = out_reg.pc;
  assign out_instr = out_reg.instr;
  assign rd        = out_reg.rd;
  assign rs1       = out_reg.rs1;
  assign rs2       = out_reg.rs2;
  assign imm       = out_reg.imm;
  assign alu_op    = out_reg.alu_op;
  assign rd_we     = out_reg.rd_we;
  assign uses_rs1  = out_reg.uses_rs1;
  assign uses_rs2  = out_reg.uses_rs2;
  assign illegal   = out_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M enabled / disabled) share one
// stimulus stream; a queue-based occupancy model and an encoding-table
// decoder supply every expected value.
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready_m, out_valid_m, rd_we_m, uses_rs1_m, uses_rs2_m, illegal_m;
  logic [31:0] out_pc_m, out_instr_m, imm_m;
  logic [4:0]  rd_m, rs1_m, rs2_m, alu_op_m;
  logic        in_ready_n, out_valid_n, rd_we_n, uses_rs1_n, uses_rs2_n, illegal_n;
  logic [31:0] out_pc_n, out_instr_n, imm_n;
  logic [4:0]  rd_n, rs1_n, rs2_n, alu_op_n;

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .SKID(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_pc(out_pc_m), .out_instr(out_instr_m), .rd(rd_m), .rs1(rs1_m), .rs2(rs2_m),
    .imm(imm_m), .alu_op(alu_op_m), .rd_we(rd_we_m), .uses_rs1(uses_rs1_m),
    .uses_rs2(uses_rs2_m), .illegal(illegal_m)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .SKID(1'b1)) dut_n (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_pc(out_pc_n), .out_instr(out_instr_n), .rd(rd_n), .rs1(rs1_n), .rs2(rs2_n),
    .imm(imm_n), .alu_op(alu_op_n), .rd_we(rd_we_n), .uses_rs1(uses_rs1_n),
    .uses_rs2(uses_rs2_n), .illegal(illegal_n)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  localparam int F_R = 0, F_I = 1, F_S = 2, F_B = 3, F_J = 4, F_U = 5;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [4:0]  alu;
    int          fmt;
    bit          writes;
    bit          is_m;
  } enc_t;

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        rd_we, u1, u2, ill;
  } ref_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  enc_t  enc_table[$];
  item_t q[$];

  function automatic void add_enc(input logic [31:0] mask, input logic [31:0] match,
                                  input logic [4:0] alu, input int fmt, input bit writes,
                                  input bit is_m);
    enc_t e;
    e.mask = mask; e.match = match; e.alu = alu; e.fmt = fmt; e.writes = writes; e.is_m = is_m;
    enc_table.push_back(e);
  endfunction

  // ISA encoding table (mask/match) for the RV32IM subset.
  function automatic void build_table();
    logic [31:0] rm, im, om;
    rm = 32'hFE00707F; im = 32'h0000707F; om = 32'h0000007F;
    add_enc(rm, 32'h00000033, 5'd2,  F_R, 1, 0); // ADD
    add_enc(rm, 32'h40000033, 5'd6,  F_R, 1, 0); // SUB
    add_enc(rm, 32'h00001033, 5'd4,  F_R, 1, 0); // SLL
    add_enc(rm, 32'h00002033, 5'd7,  F_R, 1, 0); // SLT
    add_enc(rm, 32'h00003033, 5'd8,  F_R, 1, 0); // SLTU
    add_enc(rm, 32'h00004033, 5'd3,  F_R, 1, 0); // XOR
    add_enc(rm, 32'h00005033, 5'd5,  F_R, 1, 0); // SRL
    add_enc(rm, 32'h40005033, 5'd16, F_R, 1, 0); // SRA
    add_enc(rm, 32'h00006033, 5'd1,  F_R, 1, 0); // OR
    add_enc(rm, 32'h00007033, 5'd0,  F_R, 1, 0); // AND
    add_enc(rm, 32'h02000033, 5'd9,  F_R, 1, 1); // MUL
    add_enc(rm, 32'h02001033, 5'd10, F_R, 1, 1); // MULH
    add_enc(rm, 32'h02002033, 5'd11, F_R, 1, 1); // MULHSU
    add_enc(rm, 32'h02003033, 5'd12, F_R, 1, 1); // MULHU
    add_enc(rm, 32'h02004033, 5'd13, F_R, 1, 1); // DIV
    add_enc(rm, 32'h02005033, 5'd14, F_R, 1, 1); // DIVU
    add_enc(rm, 32'h02006033, 5'd15, F_R, 1, 1); // REM
    add_enc(rm, 32'h02007033, 5'd17, F_R, 1, 1); // REMU
    add_enc(im, 32'h00000013, 5'd2,  F_I, 1, 0); // ADDI
    add_enc(im, 32'h00002013, 5'd7,  F_I, 1, 0); // SLTI
    add_enc(im, 32'h00003013, 5'd8,  F_I, 1, 0); // SLTIU
    add_enc(im, 32'h00004013, 5'd3,  F_I, 1, 0); // XORI
    add_enc(im, 32'h00006013, 5'd1,  F_I, 1, 0); // ORI
    add_enc(im, 32'h00007013, 5'd0,  F_I, 1, 0); // ANDI
    add_enc(rm, 32'h00001013, 5'd4,  F_I, 1, 0); // SLLI
    add_enc(rm, 32'h00005013, 5'd5,  F_I, 1, 0); // SRLI
    add_enc(rm, 32'h40005013, 5'd16, F_I, 1, 0); // SRAI
    add_enc(im, 32'h00000003, 5'd2,  F_I, 1, 0); // LB
    add_enc(im, 32'h00001003, 5'd2,  F_I, 1, 0); // LH
    add_enc(im, 32'h00002003, 5'd2,  F_I, 1, 0); // LW
    add_enc(im, 32'h00004003, 5'd2,  F_I, 1, 0); // LBU
    add_enc(im, 32'h00005003, 5'd2,  F_I, 1, 0); // LHU
    add_enc(im, 32'h00000023, 5'd2,  F_S, 0, 0); // SB
    add_enc(im, 32'h00001023, 5'd2,  F_S, 0, 0); // SH
    add_enc(im, 32'h00002023, 5'd2,  F_S, 0, 0); // SW
    add_enc(im, 32'h00000063, 5'd6,  F_B, 0, 0); // BEQ
    add_enc(im, 32'h00001063, 5'd6,  F_B, 0, 0); // BNE
    add_enc(im, 32'h00004063, 5'd6,  F_B, 0, 0); // BLT
    add_enc(im, 32'h00005063, 5'd6,  F_B, 0, 0); // BGE
    add_enc(im, 32'h00006063, 5'd6,  F_B, 0, 0); // BLTU
    add_enc(im, 32'h00007063, 5'd6,  F_B, 0, 0); // BGEU
    add_enc(im, 32'h00000067, 5'd2,  F_I, 1, 0); // JALR
    add_enc(om, 32'h0000006F, 5'd2,  F_J, 1, 0); // JAL
    add_enc(om, 32'h00000037, 5'd2,  F_U, 1, 0); // LUI
    add_enc(om, 32'h00000017, 5'd2,  F_U, 1, 0); // AUIPC
  endfunction

  // Reference decode: table lookup plus arithmetic immediate reconstruction.
  function automatic ref_t ref_decode(input logic [31:0] x, input bit en_m);
    ref_t r;
    logic [31:0] ii, v;
    r.imm = 32'd0; r.alu = 5'd2; r.rd_we = 1'b0; r.u1 = 1'b0; r.u2 = 1'b0; r.ill = 1'b1;
    ii = 32'($signed(x) >>> 20);
    foreach (enc_table[k]) begin
      if (((x & enc_table[k].mask) == enc_table[k].match) && (en_m || !enc_table[k].is_m)) begin
        r.ill   = 1'b0;
        r.alu   = enc_table[k].alu;
        r.rd_we = enc_table[k].writes && (((x >> 7) & 32'h1F) != 32'd0);
        r.u1    = enc_table[k].fmt inside {F_R, F_I, F_S, F_B};
        r.u2    = enc_table[k].fmt inside {F_R, F_S, F_B};
        case (enc_table[k].fmt)
          F_I: r.imm = ii;
          F_S: r.imm = (ii & ~32'h1F) | ((x >> 7) & 32'h1F);
          F_B: begin
            v = (((x >> 8) & 32'hF) << 1) | (((x >> 25) & 32'h3F) << 5) | (((x >> 7) & 32'h1) << 11);
            if (x[31]) v = v | 32'hFFFFF000;
            r.imm = v;
          end
          F_J: begin
            v = (((x >> 21) & 32'h3FF) << 1) | (((x >> 20) & 32'h1) << 11) | (((x >> 12) & 32'hFF) << 12);
            if (x[31]) v = v | 32'hFFF00000;
            r.imm = v;
          end
          F_U: r.imm = x & 32'hFFFFF000;
          default: r.imm = 32'd0;
        endcase
      end
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string who, input bit en_m, input logic ov, input logic ir,
                           input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] im,
                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] alu, input logic we, input logic r1,
                           input logic r2, input logic il);
    ref_t r;
    check_eq({who, ".out_valid"}, 32'(ov), 32'(q.size() > 0));
    check_eq({who, ".in_ready"}, 32'(ir), 32'(rst_n && (q.size() < 2)));
    if (q.size() > 0) begin
      r = ref_decode(q[0].instr, en_m);
      check_eq({who, ".out_pc"}, pc, q[0].pc);
      check_eq({who, ".out_instr"}, ins, q[0].instr);
      check_eq({who, ".regs"}, {17'd0, d, s1, s2},
               {17'd0, 5'((q[0].instr >> 7) & 31), 5'((q[0].instr >> 15) & 31), 5'((q[0].instr >> 20) & 31)});
      check_eq({who, ".imm"}, im, r.imm);
      check_eq({who, ".alu_op"}, 32'(alu), 32'(r.alu));
      check_eq({who, ".flags"}, {28'd0, we, r1, r2, il}, {28'd0, r.rd_we, r.u1, r.u2, r.ill});
    end
  endtask

  // One clock: drive at the falling edge, check, advance the model at the rising edge.
  task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl, input bit rn);
    bit do_pop, do_push;
    item_t it;
    rst_n = rn; flush = fl; in_valid = v; in_instr = ins; in_pc = $urandom; out_ready = ordy;
    #1;
    if (armed) begin
      check_dut("m", 1'b1, out_valid_m, in_ready_m, out_pc_m, out_instr_m, imm_m, rd_m, rs1_m,
                rs2_m, alu_op_m, rd_we_m, uses_rs1_m, uses_rs2_m, illegal_m);
      check_dut("n", 1'b0, out_valid_n, in_ready_n, out_pc_n, out_instr_n, imm_n, rd_n, rs1_n,
                rs2_n, alu_op_n, rd_we_n, uses_rs1_n, uses_rs2_n, illegal_n);
    end
    do_pop  = (q.size() > 0) && ordy;
    do_push = v && rn && (q.size() < 2);
    it.pc = in_pc; it.instr = ins;
    @(posedge clk);
    if (!rn || fl) begin
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(it);
    end
    if (!rn) armed = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    int sel;
    logic [31:0] r;
    int k;
    sel = $urandom_range(0, 9);
    r = $urandom;
    if (sel < 6) begin
      k = $urandom_range(0, enc_table.size() - 1);
      r = (r & ~enc_table[k].mask) | enc_table[k].match;
    end else if (sel < 9) begin
      case ($urandom_range(0, 8))
        0: r[6:0] = 7'b0110011;
        1: r[6:0] = 7'b0010011;
        2: r[6:0] = 7'b0000011;
        3: r[6:0] = 7'b0100011;
        4: r[6:0] = 7'b1100011;
        5: r[6:0] = 7'b1100111;
        6: r[6:0] = 7'b1101111;
        7: r[6:0] = 7'b0110111;
        default: r[6:0] = 7'b0010111;
      endcase
    end
    return r;
  endfunction

  initial begin
    build_table();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; out_ready = 1'b0;
    @(negedge clk);

    // Reset state
    step(0, 32'd0, 0, 0, 0);
    step(0, 32'd0, 0, 0, 0);
    check_eq("rst_out_valid", 32'(out_valid_m), 32'd0);
    check_eq("rst_alu_op", 32'(alu_op_m), 32'h2);
    check_eq("rst_imm", imm_m, 32'd0);
    check_eq("rst_instr", out_instr_m, 32'd0);
    check_eq("rst_in_ready", 32'(in_ready_m), 32'd0);
    step(0, 32'd0, 1, 0, 1);
    check_eq("rel_in_ready", 32'(in_ready_m), 32'd1);

    // ADD then SUB streamed
    step(1, 32'h002081B3, 1, 0, 1);
    check_eq("add_alu", 32'(alu_op_m), 32'h02);
    check_eq("add_rd_we", 32'(rd_we_m), 32'd1);
    check_eq("add_rs2", 32'(uses_rs2_m), 32'd1);
    step(1, 32'h402081B3, 1, 0, 1);
    check_eq("sub_alu", 32'(alu_op_m), 32'h06);
    check_eq("sub_valid", 32'(out_valid_m), 32'd1);

    // SRAI / REMU / BEQ / JAL x0
    step(1, 32'h4032D293, 1, 0, 1);
    check_eq("srai_alu", 32'(alu_op_m), 32'h10);
    check_eq("srai_imm", imm_m, 32'h00000403);
    step(1, 32'h023170B3, 1, 0, 1);
    check_eq("remu_alu", 32'(alu_op_m), 32'h11);
    check_eq("remu_noM_illegal", 32'(illegal_n), 32'd1);
    check_eq("remu_noM_rd_we", 32'(rd_we_n), 32'd0);
    step(1, 32'hFE000EE3, 1, 0, 1);
    check_eq("beq_imm", imm_m, 32'hFFFFFFFC);
    check_eq("beq_alu", 32'(alu_op_m), 32'h06);
    check_eq("beq_rd_we", 32'(rd_we_m), 32'd0);
    step(1, 32'h0000006F, 1, 0, 1);
    check_eq("jal_x0_rd_we", 32'(rd_we_m), 32'd0);
    check_eq("jal_x0_illegal", 32'(illegal_m), 32'd0);
    step(0, 32'd0, 1, 0, 1);

    // Back-pressure: three beats, out_ready low
    step(1, 32'h00100093, 0, 0, 1);
    step(1, 32'h00200113, 0, 0, 1);
    check_eq("bp_in_ready", 32'(in_ready_m), 32'd0);
    step(1, 32'h00300193, 0, 0, 1);
    check_eq("bp_head_held", out_instr_m, 32'h00100093);
    step(1, 32'h00300193, 1, 0, 1);
    check_eq("bp_second", out_instr_m, 32'h00200113);
    step(1, 32'h00300193, 1, 0, 1);
    check_eq("bp_third", out_instr_m, 32'h00300193);
    step(0, 32'd0, 1, 0, 1);

    // Flush with two entries buffered and a same-cycle beat
    step(1, 32'h00500293, 0, 0, 1);
    step(1, 32'h00600313, 0, 0, 1);
    step(1, 32'h00700393, 0, 1, 1);
    check_eq("flush_out_valid", 32'(out_valid_m), 32'd0);
    check_eq("flush_in_ready", 32'(in_ready_m), 32'd1);
    step(1, 32'h00800413, 1, 1, 1);
    check_eq("flush_same_beat", 32'(out_valid_m), 32'd0);
    step(0, 32'd0, 1, 0, 1);
    step(0, 32'd0, 1, 0, 1);

    // All-zero and all-one words
    step(1, 32'h00000000, 1, 0, 1);
    check_eq("zero_illegal", 32'(illegal_m), 32'd1);
    check_eq("zero_imm", imm_m, 32'd0);
    step(1, 32'hFFFFFFFF, 1, 0, 1);
    check_eq("ones_illegal", 32'(illegal_m), 32'd1);
    check_eq("ones_imm", imm_m, 32'd0);
    check_eq("ones_rd_we", 32'(rd_we_m), 32'd0);

    // Reset mid-stream
    step(1, 32'h002081B3, 0, 0, 1);
    step(1, 32'h402081B3, 0, 0, 0);
    check_eq("midrst_out_valid", 32'(out_valid_m), 32'd0);
    check_eq("midrst_alu_op", 32'(alu_op_m), 32'h2);
    step(0, 32'd0, 1, 0, 1);
    check_eq("midrst_in_ready", 32'(in_ready_m), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 149) != 0);
    end
    step(0, 32'd0, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked RV32IM instruction decode stage that replaces the combinational decoder between fetch and execute. Each accepted instruction is fully decoded and registered: register indices, sign-extended immediate, a 5-bit ALU opcode, writeback and operand-use flags, and an illegal-instruction flag. The stage buffers up to two decoded instructions, so execute back-pressure never drops a fetch beat. A flush input discards everything in flight on a taken branch or trap.

## Interface
Parameters:
- XLEN, 32, width of the PC carried alongside each instruction.
- ENABLE_M, 1, when 1, funct7=0000001 R-type ops decode to MUL/DIV; when 0 they flag illegal.
- SKID, 1, 1 = two-entry buffer with registered in_ready; 0 = single output register with in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  discard all buffered entries and any same-cycle input beat.
- in_valid  in  1  fetch beat valid.
- in_ready  out  1  stage can accept a beat.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  execute accepts the entry.
- out_pc  out  XLEN  PC of the entry.
- out_instr  out  32  raw instruction of the entry.
- rd, rs1, rs2  out  5 each  instruction fields [11:7], [19:15], [24:20].
- imm  out  32  sign-extended immediate (I/S/B/J/U format per opcode, else 0).
- alu_op  out  5  ALU operation.
- rd_we  out  1  writes rd (never for rd=x0).
- uses_rs1, uses_rs2  out  1 each  operand read required (hazard unit).
- illegal  out  1  instruction not in RV32I/RV32IM subset.

## Operation
- alu_op: AND 00000, OR 00001, ADD 00010, XOR 00011, SLL 00100, SRL 00101, SUB 00110, SLT 00111, SLTU 01000, MUL 01001, MULH 01010, MULHSU 01011, MULHU 01100, DIV 01101, DIVU 01110, REM 01111, SRA 10000, REMU 10001.
- R-type (0110011): funct7 0000000 → base op; 0100000 legal only with funct3 000 (SUB) or 101 (SRA); 0000001 → M op when ENABLE_M; any other funct7 → illegal.
- OP-IMM (0010011): I-imm; SLLI requires funct7 0000000; funct3 101 with funct7 0000000 → SRL, 0100000 → SRA, else illegal; imm holds the full I-immediate, including shift encodings.
- Load (0000011): funct3 011/110/111 illegal. Store (0100011): funct3 ≥ 011 illegal. Branch (1100011): funct3 010/011 illegal, alu_op SUB. JALR: funct3 ≠ 000 illegal. JAL, LUI, AUIPC: alu_op ADD.
- Any other opcode, or in_instr[1:0] ≠ 11 → illegal.
- When illegal: rd_we=0, uses_rs1=uses_rs2=0, imm=0, alu_op=ADD; fields, pc and instr still pass through.
- rd_we: R, OP-IMM, load, JAL, JALR, LUI, AUIPC, and rd≠0.
- uses_rs1: R, OP-IMM, load, store, branch, JALR. uses_rs2: R, store, branch.
- Buffer (SKID=1) states:
  - EMPTY: in beat → ONE.
  - ONE: in beat without out handshake → TWO (beat held in skid); in beat with out handshake → ONE (new entry); out handshake only → EMPTY.
  - TWO: in_ready=0; out handshake → ONE, skid entry promoted to the output.
- Order is preserved.

## Timing
- Latency: a beat accepted at edge N appears on out_* after edge N (one cycle); zero added latency in steady state.
- Throughput: one instruction per cycle while out_ready=1.
- in_ready is a flop output when SKID=1 (1 in EMPTY/ONE).
- out_* are stable while out_valid && !out_ready.
- flush: at the next edge the state is EMPTY and out_valid=0; the same-cycle input beat is discarded even if in_valid && in_ready; flush has priority over every transition.
- Reset (rst_n=0 at an edge): out_valid=0, state EMPTY, all data outputs 0 except alu_op=00010; in_ready=0 while rst_n=0 and 1 in the first cycle after release. Reset mid-stream discards all entries.

## Test plan
- Stream ADD x3,x1,x2 (0x002081B3) then SUB x3,x1,x2 (0x402081B3) with out_ready=1 → alu_op 00010 then 00110, rd_we=1, uses_rs2=1, one result per cycle.
- SRAI x5,x5,3 (0x4032D293) → alu_op 10000, imm=0x00000403; REMU x1,x2,x3 (0x023170B3) → 10001; REMU with ENABLE_M=0 → illegal=1, rd_we=0.
- BEQ with imm −4 (0xFE000EE3) → imm=0xFFFFFFFC, alu_op 00110, rd_we=0; JAL x0 → rd_we=0.
- Hold out_ready=0 while sending 3 beats → after 2 accepts in_ready=0 and beat 3 waits; release → beats 1, 2, 3 emerge in order, none lost.
- With 2 entries buffered, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, no flushed or same-cycle beat ever appears.
- Opcode 0x00000000 and 0xFFFFFFFF → illegal=1, imm=0; rst_n low for one cycle mid-stream → out_valid=0, alu_op=00010.
